// File: rtl/dc_level_avg.sv
// dc_level_avg: windowed DC-level estimator.
// Sums WINDOW unsigned samples, then divides the window sum by WINDOW with a
// sequential restoring divider (one quotient bit per cycle) while the next
// window keeps accumulating.
// Optional build macro: DC_AVG_SMOOTH_EN -- when defined, each window after the
// first is blended into avg with a round-half-up first-order IIR.
module dc_level_avg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 640,
  parameter int unsigned SUM_W  = 20,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             clear,
  output logic [WIDTH-1:0] avg,
  output logic             avg_update,
  output logic             avg_ready,
  output logic             busy
);

  localparam int unsigned IT_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_done;
  logic [SUM_W-1:0] win_sum;

  state_e           state_q;
  logic             start_q;
  logic [SUM_W-1:0] dvd_q;
  logic [CNT_W-1:0] rem_q;
  logic [IT_W-1:0]  it_q;
  logic [WIDTH-1:0] avg_q;
  logic             upd_q;
  logic             ready_q;

  logic [CNT_W:0]   trial;
  logic             trial_ge;
  logic [CNT_W-1:0] rem_d;
  logic [WIDTH-1:0] avg_d;

  // Accumulator/counter next state; the WINDOW-th accepted sample closes the window.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    win_sum  = acc_q + SUM_W'(sample);
    win_done = 1'b0;
    if (sample_valid && !clear) begin
      if (cnt_q == CNT_W'(WINDOW - 1)) begin
        win_done = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = win_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Accumulator registers; clear discards the partial window and any coincident sample.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem_q, dvd_q[SUM_W-1]};
    trial_ge = (trial >= (CNT_W+1)'(WINDOW));
    rem_d    = trial_ge ? CNT_W'(trial - (CNT_W+1)'(WINDOW)) : trial[CNT_W-1:0];
  end

  // Value loaded into avg when a division finishes.
`ifdef DC_AVG_SMOOTH_EN
  logic [WIDTH:0] smooth_sum;
  always_comb begin
    smooth_sum = {1'b0, avg_q} + {1'b0, dvd_q[WIDTH-1:0]} + (WIDTH+1)'(1);
    avg_d      = ready_q ? WIDTH'(smooth_sum >> 1) : dvd_q[WIDTH-1:0];
  end
`else
  always_comb begin
    avg_d = dvd_q[WIDTH-1:0];
  end
`endif

  // Divider FSM and registered outputs. The window sum is captured into dvd_q and
  // start_q is set on the closing edge; IDLE picks it up one edge later, which
  // places the avg update SUM_W+2 edges after the final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      dvd_q   <= '0;
      rem_q   <= '0;
      it_q    <= '0;
      avg_q   <= '0;
      upd_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        start_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_q) begin
              state_q <= DIV;
              start_q <= 1'b0;
              rem_q   <= '0;
              it_q    <= '0;
            end
          end
          DIV: begin
            rem_q <= rem_d;
            dvd_q <= {dvd_q[SUM_W-2:0], trial_ge};
            it_q  <= it_q + IT_W'(1);
            if (it_q == IT_W'(SUM_W - 1)) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            avg_q   <= avg_d;
            upd_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
        if (win_done) begin
          dvd_q   <= win_sum;
          start_q <= 1'b1;
        end
      end
    end
  end

  assign avg        = avg_q;
  assign avg_update = upd_q;
  assign avg_ready  = ready_q;
  assign busy       = (state_q == DIV);

endmodule

// File: tb/tb_dc_level_avg.sv
// Directed bench for dc_level_avg: a table of single-window cases plus
// hand-written sequences for back-to-back windows, clear and reset aborts.
module tb_dc_level_avg;

  localparam int WIDTH  = 8;
  localparam int WINDOW = 640;
  localparam int SUM_W  = 20;
  localparam int CNT_W  = 10;
  localparam int LAT    = SUM_W + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sample = '0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] avg;
  logic             avg_update;
  logic             avg_ready;
  logic             busy;

  dc_level_avg #(.WIDTH(WIDTH), .WINDOW(WINDOW), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .clear(clear), .avg(avg), .avg_update(avg_update), .avg_ready(avg_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  int upd_total = 0;
  int upd_edge = 0;
  int upd_vals[64];
  int last_edge = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Pulse monitor, sampled just after each edge.
  always @(posedge clk) begin
    #2;
    if (avg_update) begin
      if (upd_total < 64) upd_vals[upd_total] = int'(avg);
      upd_edge  = edge_cnt;
      upd_total = upd_total + 1;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               gap;
    int               exp_avg;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; sample = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input int n, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample = (i % 2 == 0) ? a : b;
      last_edge = edge_cnt + 1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        sample_valid = 1'b0;
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_upd(input int target, input int budget, input string name);
    int left;
    left = budget;
    while (upd_total < target && left > 0) begin
      @(negedge clk);
      left--;
    end
    if (upd_total < target) check(name, upd_total, target);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int base;
  int exp2;

  initial begin
    tbl[0] = '{a: 8'd128, b: 8'd128, gap: 0, exp_avg: 128};
    tbl[1] = '{a: 8'd0,   b: 8'd255, gap: 0, exp_avg: 127};
    tbl[2] = '{a: 8'd255, b: 8'd255, gap: 0, exp_avg: 255};
    tbl[3] = '{a: 8'd0,   b: 8'd0,   gap: 0, exp_avg: 0};
    tbl[4] = '{a: 8'd7,   b: 8'd8,   gap: 1, exp_avg: 7};

    // Table: each entry is a fresh first window after reset.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      check("rst_avg", int'(avg), 0);
      check("rst_ready", int'(avg_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_update", int'(avg_update), 0);
      base = upd_total;
      send(WINDOW, tbl[t].a, tbl[t].b, tbl[t].gap);
      wait_upd(base + 1, 60, "tbl_timeout");
      check("tbl_avg", upd_vals[base], tbl[t].exp_avg);
      check("tbl_latency", upd_edge - last_edge, LAT);
      idle(30);
      check("tbl_pulses", upd_total - base, 1);
      check("tbl_ready", int'(avg_ready), 1);
      check("tbl_busy_idle", int'(busy), 0);
    end

    // Full-scale window then zero window.
    do_reset();
    base = upd_total;
    send(WINDOW, 8'd255, 8'd255, 0);
    wait_upd(base + 1, 60, "fs_timeout1");
    check("fs_avg1", int'(avg), 255);
    send(WINDOW, 8'd0, 8'd0, 0);
    wait_upd(base + 2, 60, "fs_timeout2");
`ifdef DC_AVG_SMOOTH_EN
    exp2 = 128;
`else
    exp2 = 0;
`endif
    check("fs_avg2", int'(avg), exp2);
    idle(30);
    check("fs_pulses", upd_total - base, 2);

    // Clear coincident with a sample: both the partial window and that sample are dropped.
    do_reset();
    base = upd_total;
    send(300, 8'd200, 8'd200, 0);
    @(negedge clk);
    clear = 1'b1; sample_valid = 1'b1; sample = 8'd255;
    @(negedge clk);
    clear = 1'b0; sample_valid = 1'b0;
    send(WINDOW, 8'd50, 8'd50, 0);
    wait_upd(base + 1, 60, "clr_timeout");
    check("clr_avg", int'(avg), 50);
    check("clr_latency", upd_edge - last_edge, LAT);
    idle(30);
    check("clr_pulses", upd_total - base, 1);

    // Clear 5 cycles into a divide: busy drops, no pulse, avg/ready held.
    base = upd_total;
    send(WINDOW, 8'd100, 8'd100, 0);
    idle(6);
    check("clrdiv_busy_before", int'(busy), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clrdiv_busy_after", int'(busy), 0);
    idle(40);
    check("clrdiv_pulses", upd_total - base, 0);
    check("clrdiv_avg_held", int'(avg), 50);
    check("clrdiv_ready_held", int'(avg_ready), 1);
    send(WINDOW, 8'd100, 8'd100, 0);
    wait_upd(base + 1, 60, "clrdiv_timeout");
`ifdef DC_AVG_SMOOTH_EN
    exp2 = 75;
`else
    exp2 = 100;
`endif
    check("clrdiv_next_avg", int'(avg), exp2);

    // Reset 5 cycles into a divide.
    do_reset();
    send(WINDOW, 8'd128, 8'd128, 0);
    wait_upd(upd_total + 1, 60, "rstdiv_timeout");
    check("rstdiv_ready_pre", int'(avg_ready), 1);
    base = upd_total;
    send(WINDOW, 8'd128, 8'd128, 0);
    idle(6);
    check("rstdiv_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstdiv_avg", int'(avg), 0);
    check("rstdiv_ready", int'(avg_ready), 0);
    check("rstdiv_busy", int'(busy), 0);
    check("rstdiv_update", int'(avg_update), 0);
    idle(40);
    check("rstdiv_pulses", upd_total - base, 0);

    // 1-in-3 duty, second window overlaps the first divide.
    do_reset();
    base = upd_total;
    send(WINDOW, 8'd100, 8'd100, 2);
    send(WINDOW, 8'd200, 8'd200, 2);
    wait_upd(base + 2, 100, "duty_timeout");
    check("duty_avg1", upd_vals[base], 100);
`ifdef DC_AVG_SMOOTH_EN
    exp2 = 150;
`else
    exp2 = 200;
`endif
    check("duty_avg2", upd_vals[base + 1], exp2);
    check("duty_latency2", upd_edge - last_edge, LAT);
    idle(30);
    check("duty_pulses", upd_total - base, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
